// File: rtl/dwc_upsizer.sv
// Narrow-to-wide AXI-Stream width converter: gathers OUT_FOLD/IN_FOLD input words into one output word.
// Optional tlast support (early group completion, zero-filled lanes) is enabled by DWC_UPSIZER_TLAST_EN.
module dwc_upsizer #(
  parameter int ACTIVATION_WIDTH = 4,
  parameter int IN_FOLD          = 2,
  parameter int OUT_FOLD         = 10,
  localparam int IN_BA  = (IN_FOLD * ACTIVATION_WIDTH + 7) / 8 * 8,
  localparam int OUT_BA = (OUT_FOLD * ACTIVATION_WIDTH + 7) / 8 * 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [IN_BA-1:0]  s_axis_input_tdata,
  input  logic              s_axis_input_tvalid,
  output logic              s_axis_input_tready,
`ifdef DWC_UPSIZER_TLAST_EN
  input  logic              s_axis_input_tlast,
  output logic              m_axis_output_tlast,
`endif
  output logic [OUT_BA-1:0] m_axis_output_tdata,
  output logic              m_axis_output_tvalid,
  input  logic              m_axis_output_tready
);

  localparam int RATIO = OUT_FOLD / IN_FOLD;
  localparam int IN_W  = IN_FOLD * ACTIVATION_WIDTH;
  localparam int OUT_W = OUT_FOLD * ACTIVATION_WIDTH;
  localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int ASM_W = (RATIO - 1) * IN_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  generate
    if ((OUT_FOLD % IN_FOLD) != 0 || OUT_FOLD <= IN_FOLD) begin : g_bad_cfg
      $error("dwc_upsizer: OUT_FOLD must be a multiple of IN_FOLD and larger than it");
    end
    if (IN_BA > IN_W) begin : g_in_pad
      logic unused_in_pad;
      assign unused_in_pad = ^s_axis_input_tdata[IN_BA-1:IN_W];
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [ASM_W-1:0] asm_q;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q;
  logic [IN_W-1:0]  in_word;
  logic [OUT_W-1:0] full_word;
  logic             completes;
  logic             in_hs;
  logic             out_hs;

  assign in_word = s_axis_input_tdata[IN_W-1:0];

`ifdef DWC_UPSIZER_TLAST_EN
  logic out_last_q;
  assign completes           = (cnt_q == LAST_CNT) || s_axis_input_tlast;
  assign m_axis_output_tlast = out_last_q;
`else
  assign completes = (cnt_q == LAST_CNT);
`endif

  // The only stall: a group-completing word while the held output cannot drain.
  assign s_axis_input_tready  = !(completes && out_valid_q && !m_axis_output_tready);
  assign in_hs                = s_axis_input_tvalid && s_axis_input_tready;
  assign out_hs               = out_valid_q && m_axis_output_tready;
  assign m_axis_output_tvalid = out_valid_q;
  assign m_axis_output_tdata  = OUT_BA'(out_q);

  // Filled slots below cnt come from the assembly register, the incoming word
  // takes slot cnt, and any lanes above it (early tlast) stay zero.
  always_comb begin
    full_word = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (CNT_W'(k) < cnt_q) begin
        full_word[k*IN_W +: IN_W] = asm_q[k*IN_W +: IN_W];
      end
    end
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) == cnt_q) begin
        full_word[k*IN_W +: IN_W] = in_word;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_hs) begin
        out_valid_q <= 1'b0;
      end
      if (in_hs) begin
        if (completes) begin
          out_q       <= full_word;
          out_valid_q <= 1'b1;
          cnt_q       <= '0;
        end else begin
          for (int k = 0; k < RATIO - 1; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              asm_q[k*IN_W +: IN_W] <= in_word;
            end
          end
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef DWC_UPSIZER_TLAST_EN
  // tlast travels with the word it completes and is held alongside the data.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_last_q <= 1'b0;
    end else if (in_hs && completes) begin
      out_last_q <= s_axis_input_tlast;
    end
  end
`endif

endmodule

// File: doc/dwc_upsizer.md
# dwc_upsizer

Stream data-width converter, narrow to wide. The block collects `RATIO = OUT_FOLD/IN_FOLD` consecutive input words of `IN_FOLD` activations each, then emits one output word of `OUT_FOLD` activations. It sits between a low-parallelism producer and a high-parallelism consumer on AXI-Stream. It is the gathering counterpart of the existing downsizing DWC.

## Interface
- `ACTIVATION_WIDTH`, default 4: bits per activation.
- `IN_FOLD`, default 2: activations per input word.
- `OUT_FOLD`, default 10: activations per output word. Must satisfy `OUT_FOLD % IN_FOLD == 0` and `OUT_FOLD > IN_FOLD`; elaboration fails otherwise.
- Derived `IN_BA = (IN_FOLD*ACTIVATION_WIDTH+7)/8*8` and `OUT_BA = (OUT_FOLD*ACTIVATION_WIDTH+7)/8*8` (byte-aligned stream widths).

Ports:
- `ap_clk`  in  1  sole clock, rising edge.
- `ap_rst`  in  1  asynchronous reset, active-high.
- `s_axis_input_tdata`  in  `IN_BA`  input word; bits at and above `IN_FOLD*ACTIVATION_WIDTH` are ignored.
- `s_axis_input_tvalid`  in  1  input valid.
- `s_axis_input_tready`  out  1  input ready.
- `m_axis_output_tdata`  out  `OUT_BA`  output word; pad bits driven 0.
- `m_axis_output_tvalid`  out  1  output valid.
- `m_axis_output_tready`  in  1  output ready.

## Operation
- Lane mapping: input word k (k = 0..RATIO-1, counted from the start of a group) lands in output lanes `[k*IN_FOLD +: IN_FOLD]`. Lane j occupies bits `[j*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]`, so the earliest word goes into the least-significant bits.
- State:
  - fill counter `cnt`, range 0..RATIO-1, width `$clog2(RATIO)` (minimum 1);
  - assembly register holding the first RATIO-1 words;
  - output register plus `m_axis_output_tvalid` flag.
- Input handshake (`tvalid && tready`) with `cnt < RATIO-1`: write the word into assembly slot `cnt`, then `cnt++`.
- Input handshake with `cnt == RATIO-1`: load the output register with {input word, assembly contents}, set output valid, and wrap `cnt` to 0.
- Output handshake: clear output valid unless the same cycle loads a new word. In that case valid stays 1 and the data updates.
- `s_axis_input_tready = !(cnt == RATIO-1 && m_tvalid && !m_tready)`. The block stalls only when the completing word has no free output slot. Words that are not completing are always accepted, even while the output is held.
- Output data is stable while `tvalid && !tready` (AXI rule).
- Assembly contents are not cleared on wrap. Stale data never appears in the output because every slot is rewritten before the next completion.

## Timing
- Reset values: `m_axis_output_tvalid = 0`, `m_axis_output_tdata = 0`, `cnt = 0`, `s_axis_input_tready = 1` (combinational from the reset state).
- Latency: the output is valid in the cycle after the completing input handshake.
- Throughput: one input word per cycle sustained while the consumer is ready. Output rate is 1/RATIO per cycle.
- No combinational path from `s_axis_input_tvalid` to any output. `s_axis_input_tready` depends combinationally on `m_axis_output_tready`.
- Simultaneous completing input and output handshake: the new word replaces the old one with no bubble.
- Reset mid-group: the partial group is discarded and the next accepted word becomes lane group 0.
- Reset while output valid and unconsumed: the word is dropped and valid falls asynchronously.

## Configuration
- `DWC_UPSIZER_TLAST_EN` defined: adds ports `s_axis_input_tlast` (in, 1) and `m_axis_output_tlast` (out, 1, reset 0).
  - An input handshake with tlast=1 completes the group at any `cnt`.
  - Unfilled lanes are output as 0, `m_axis_output_tlast=1`, and `cnt` returns to 0.
  - `tready` uses "this word completes" (`cnt == RATIO-1 || tlast`) in place of `cnt == RATIO-1`.
  - tlast on the naturally completing word simply sets `m_axis_output_tlast=1`.
- `DWC_UPSIZER_TLAST_EN` undefined: the tlast ports do not exist and groups always complete at exactly RATIO words.

## Test plan
- Defaults (RATIO=5), ready held 1, inputs 0x10,0x32,0x54,0x76,0x98 on consecutive cycles → one output `0x9876543210` one cycle after the fifth handshake; `tready` stays 1 throughout.
- Back-to-back groups with ready=1 for 20 input words → 4 outputs spaced exactly 5 cycles apart, with no dropped or duplicated words.
- Output tready held 0 after the first output → 4 further inputs are accepted, the 5th sees `tready=0`, and output data stays unchanged. Releasing ready gives the second word on the following cycle.
- Randomized tvalid/tready (tready 4/7 duty), 200 groups → the scoreboard matches the lane mapping; pad bits of output tdata are always 0.
- Assert `ap_rst` after 3 of 5 words, then send 5 fresh words → the output contains only the fresh words; tvalid is 0 immediately at reset assertion.
- With `DWC_UPSIZER_TLAST_EN`: inputs 0x21,0x43 with tlast on 0x43 → output `0x0000004321` with tlast=1. The next group then starts in lanes 0-1.
